// File: rtl/mont_mul_seq.sv
// Bit-serial Montgomery multiplication sequencer: computes A*B*2^-N mod M by
// stepping an external mpadder accumulator through add/halve/subtract/restore.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; all adder controls low
// CLEAR  | zero the adder accumulator
// ADD_B  | C += b_i ? A : 0
// ADD_M  | C = (C + (C odd ? M : 0)) / 2, advance to next bit of B
// SUB    | C -= M
// FIX    | C += M if the subtraction went negative
// FINISH | capture accumulator into result, pulse done
module mont_mul_seq #(
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic [N+1:0] adder_in_a,
  output logic         adder_subtract,
  output logic         adder_shift,
  output logic         adder_enableC,
  output logic         adder_cZero,
  input  logic [N+2:0] adder_result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD_B,
    ADD_M,
    SUB,
    FIX,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  m_q;
  logic [CW-1:0] cnt_q;

  // Bits N+1:N of the accumulator only matter inside the adder; the sequencer
  // needs the low N bits, bit 0 and the sign.
  logic unused_acc_bits;
  assign unused_acc_bits = ^adder_result[N+1:N];

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Operand latches, B shift register, bit counter, result and done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            cnt_q <= '0;
          end
        end
        ADD_M: begin
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
        FINISH: begin
          result <= adder_result[N-1:0];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and adder control decode.
  always_comb begin
    state_nxt      = state;
    busy           = (state != IDLE);
    adder_in_a     = '0;
    adder_subtract = 1'b0;
    adder_shift    = 1'b0;
    adder_enableC  = 1'b0;
    adder_cZero    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        adder_cZero = 1'b1;
        state_nxt   = ADD_B;
      end
      ADD_B: begin
        adder_enableC = 1'b1;
        adder_in_a    = b_q[0] ? {2'b00, a_q} : '0;
        state_nxt     = ADD_M;
      end
      ADD_M: begin
        adder_enableC = 1'b1;
        adder_shift   = 1'b1;
        adder_in_a    = adder_result[0] ? {2'b00, m_q} : '0;
        state_nxt     = (cnt_q == LAST_BIT) ? SUB : ADD_B;
      end
      SUB: begin
        adder_enableC  = 1'b1;
        adder_subtract = 1'b1;
        adder_in_a     = {2'b00, m_q};
        state_nxt      = FIX;
      end
      FIX: begin
        adder_enableC = 1'b1;
        adder_in_a    = adder_result[N+2] ? {2'b00, m_q} : '0;
        state_nxt     = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mont_mul_seq.sv
// Bench for mont_mul_seq: a 4-bit instance for hand-computed vectors and a
// 512-bit instance for random vectors, each paired with a behavioural mpadder.
module tb_mont_mul_seq;

  localparam int NS = 4;
  localparam int NL = 512;
  localparam int TS = 2 * NS + 4;
  localparam int TL = 2 * NL + 4;
  localparam int NV = 40;

  typedef logic [1039:0] big_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // small instance
  logic          s_rstn, s_start;
  logic [NS-1:0] s_a, s_b, s_m, s_res;
  logic          s_done, s_busy, s_sub, s_sh, s_en, s_cz;
  logic [NS+1:0] s_ain;
  logic [NS+2:0] s_c = '0;

  // large instance
  logic          l_rstn, l_start;
  logic [NL-1:0] l_a, l_b, l_m, l_res;
  logic          l_done, l_busy, l_sub, l_sh, l_en, l_cz;
  logic [NL+1:0] l_ain;
  logic [NL+2:0] l_c = '0;

  mont_mul_seq #(.N(NS)) u_small (
    .clk(clk), .resetn(s_rstn), .start(s_start),
    .in_a(s_a), .in_b(s_b), .in_m(s_m),
    .result(s_res), .done(s_done), .busy(s_busy),
    .adder_in_a(s_ain), .adder_subtract(s_sub), .adder_shift(s_sh),
    .adder_enableC(s_en), .adder_cZero(s_cz), .adder_result(s_c)
  );

  mont_mul_seq #(.N(NL)) u_large (
    .clk(clk), .resetn(l_rstn), .start(l_start),
    .in_a(l_a), .in_b(l_b), .in_m(l_m),
    .result(l_res), .done(l_done), .busy(l_busy),
    .adder_in_a(l_ain), .adder_subtract(l_sub), .adder_shift(l_sh),
    .adder_enableC(l_en), .adder_cZero(l_cz), .adder_result(l_c)
  );

  // mpadder behaviour for the small instance
  always @(posedge clk) begin : s_adder
    logic [NS+2:0] sum;
    sum = s_sub ? s_c - {1'b0, s_ain} : s_c + {1'b0, s_ain};
    if (s_cz)      s_c <= '0;
    else if (s_en) s_c <= s_sh ? $signed(sum) >>> 1 : sum;
  end

  // mpadder behaviour for the large instance
  always @(posedge clk) begin : l_adder
    logic [NL+2:0] sum;
    sum = l_sub ? l_c - {1'b0, l_ain} : l_c + {1'b0, l_ain};
    if (l_cz)      l_c <= '0;
    else if (l_en) l_c <= l_sh ? $signed(sum) >>> 1 : sum;
  end

  // A*B*2^-n mod m: 2^-1 mod odd m is applied n times to 1 by halving.
  function automatic big_t ref_mont(big_t a, big_t b, big_t m, int n);
    big_t x;
    x = 1;
    for (int i = 0; i < n; i++) x = x[0] ? (x + m) >> 1 : x >> 1;
    return (((a * b) % m) * x) % m;
  endfunction

  function automatic big_t rnd512();
    big_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input big_t act, input big_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction models: cycle position since the accepted start (1..2n+4 busy,
  // 2n+5 is the done cycle), latched operands and the expected held result.
  int   s_cnt = 0, l_cnt = 0;
  bit   s_rst_seen = 1'b0, l_rst_seen = 1'b0;
  big_t s_ea, s_eb, s_em, s_eres = '0;
  big_t l_ea, l_eb, l_em, l_eres = '0;

  always @(posedge clk) begin
    s_rst_seen = 1'b0;
    if (!s_rstn) begin
      s_cnt = 0; s_eres = '0; s_rst_seen = 1'b1;
    end else if ((s_cnt == 0 || s_cnt == TS + 1) && s_start) begin
      s_cnt = 1; s_ea = big_t'(s_a); s_eb = big_t'(s_b); s_em = big_t'(s_m);
    end else if (s_cnt == TS) begin
      s_cnt = TS + 1; s_eres = ref_mont(s_ea, s_eb, s_em, NS);
    end else if (s_cnt == TS + 1) s_cnt = 0;
    else if (s_cnt != 0) s_cnt++;
  end

  always @(posedge clk) begin
    l_rst_seen = 1'b0;
    if (!l_rstn) begin
      l_cnt = 0; l_eres = '0; l_rst_seen = 1'b1;
    end else if ((l_cnt == 0 || l_cnt == TL + 1) && l_start) begin
      l_cnt = 1; l_ea = big_t'(l_a); l_eb = big_t'(l_b); l_em = big_t'(l_m);
    end else if (l_cnt == TL) begin
      l_cnt = TL + 1; l_eres = ref_mont(l_ea, l_eb, l_em, NL);
    end else if (l_cnt == TL + 1) l_cnt = 0;
    else if (l_cnt != 0) l_cnt++;
  end

  task automatic cmp(input string tag, input int n, input int cnt, input bit rst_seen,
                     input big_t ea, input big_t eb, input big_t em, input big_t eres,
                     input big_t c, input logic busy, input logic done, input big_t res,
                     input big_t ain, input logic sub, input logic sh, input logic en,
                     input logic cz);
    int i;
    chk({tag, "_busy"}, big_t'(busy), big_t'(cnt >= 1 && cnt <= 2 * n + 4));
    chk({tag, "_done"}, big_t'(done), big_t'(cnt == 2 * n + 5));
    chk({tag, "_result"}, res, eres);
    if (rst_seen) begin
      chk({tag, "_rst_ctl"}, big_t'({sub, sh, en, cz}), '0);
      chk({tag, "_rst_in_a"}, ain, '0);
    end else if (cnt == 1) begin
      chk({tag, "_clear_ctl"}, big_t'({cz, en}), big_t'(2'b10));
    end else if (cnt >= 2 && cnt <= 2 * n + 1) begin
      i = (cnt - 2) / 2;
      if (cnt % 2 == 0) begin
        chk({tag, "_addb_ctl"}, big_t'({cz, en, sub, sh}), big_t'(4'b0100));
        chk({tag, "_addb_in_a"}, ain, eb[i] ? ea : '0);
      end else begin
        chk({tag, "_addm_ctl"}, big_t'({cz, en, sub, sh}), big_t'(4'b0101));
        chk({tag, "_addm_in_a"}, ain, c[0] ? em : '0);
      end
    end else if (cnt == 2 * n + 2) begin
      chk({tag, "_sub_ctl"}, big_t'({cz, en, sub, sh}), big_t'(4'b0110));
      chk({tag, "_sub_in_a"}, ain, em);
    end else if (cnt == 2 * n + 3) begin
      chk({tag, "_fix_ctl"}, big_t'({cz, en, sub, sh}), big_t'(4'b0100));
      chk({tag, "_fix_in_a"}, ain, c[n+2] ? em : '0);
    end else if (cnt == 2 * n + 4) begin
      chk({tag, "_finish_ctl"}, big_t'({cz, en}), '0);
    end
  endtask

  // Per-cycle compare of both instances against their models.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("s", NS, s_cnt, s_rst_seen, s_ea, s_eb, s_em, s_eres, big_t'(s_c),
          s_busy, s_done, big_t'(s_res), big_t'(s_ain), s_sub, s_sh, s_en, s_cz);
      cmp("l", NL, l_cnt, l_rst_seen, l_ea, l_eb, l_em, l_eres, big_t'(l_c),
          l_busy, l_done, big_t'(l_res), big_t'(l_ain), l_sub, l_sh, l_en, l_cz);
    end
  end

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_small(input logic [NS-1:0] a, input logic [NS-1:0] b,
                           input logic [NS-1:0] m, input big_t exp);
    int k;
    s_a = a; s_b = b; s_m = m; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    k = 0;
    while (!s_done && k < TS + 8) begin @(negedge clk); k++; end
    chk("s_latency", big_t'(k), big_t'(TS));
    chk("s_vec_result", big_t'(s_res), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    big_t m, a, b;
    s_rstn = 1'b0; l_rstn = 1'b0; s_start = 1'b0; l_start = 1'b0;
    s_a = '0; s_b = '0; s_m = '0; l_a = '0; l_b = '0; l_m = '0;

    chk("ref_5_7_13", ref_mont(5, 7, 13, 4), 3);
    chk("ref_12_12_13", ref_mont(12, 12, 13, 4), 9);
    chk("ref_1_1_15", ref_mont(1, 1, 15, 4), 1);
    chk("ref_0_9_15", ref_mont(0, 9, 15, 4), 0);

    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    s_rstn = 1'b1; l_rstn = 1'b1;
    @(negedge clk);

    // hand vectors, each started in the previous done cycle
    run_small(4'd5, 4'd7, 4'd13, 3);
    run_small(4'd12, 4'd12, 4'd13, 9);
    run_small(4'd1, 4'd1, 4'd15, 1);
    run_small(4'd0, 4'd9, 4'd15, 0);

    // start pulses during a running operation are ignored
    s_a = 4'd5; s_b = 4'd7; s_m = 4'd13; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (2) @(negedge clk);
    s_a = 4'd12; s_b = 4'd12; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (3) @(negedge clk);
    s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    k = 0;
    while (!s_done && k < TS + 8) begin @(negedge clk); k++; end
    chk("s_ignore_done", big_t'(s_done), 1);
    chk("s_ignore_result", big_t'(s_res), 3);
    @(negedge clk);

    // reset mid-loop aborts the operation
    s_a = 4'd5; s_b = 4'd7; s_m = 4'd13; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (5) @(negedge clk);
    s_rstn = 1'b0;
    @(negedge clk);
    s_rstn = 1'b1;
    chk("s_abort_result", big_t'(s_res), 0);
    @(negedge clk);
    run_small(4'd5, 4'd7, 4'd13, 3);

    // random 512-bit vectors, alternating back-to-back and gapped starts
    for (int v = 0; v < NV; v++) begin
      m = rnd512(); m[0] = 1'b1;
      a = rnd512() % m;
      b = rnd512() % m;
      l_m = m[NL-1:0]; l_a = a[NL-1:0]; l_b = b[NL-1:0]; l_start = 1'b1;
      @(negedge clk); l_start = 1'b0;
      k = 0;
      while (!l_done && k < TL + 8) begin @(negedge clk); k++; end
      chk("l_latency", big_t'(k), big_t'(TL));
      chk("l_vec_result", big_t'(l_res), ref_mont(a, b, m, NL));
      if (v % 2 == 1) repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
